// File: rtl/sed_ctrl_pkg.sv
// Shared types and default constants for the SED scan controller.
package sed_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      START,
      RUN,
      CAPTURE,
      GAP
   } state_t;

   localparam int unsigned DEF_INTERVAL_CYCLES = 1024;
   localparam int unsigned DEF_SETUP_CYCLES    = 4;
   localparam int unsigned DEF_TIMEOUT_CYCLES  = 2097152;
   localparam int unsigned DEF_CNT_W           = 8;

   // Longest configuration-CRC scan of any supported device, in clkout cycles.
   localparam int unsigned MAX_SCAN_LEN = 1887748;

   // Width of the scan-duration / timeout counter.
   localparam int unsigned DUR_W = 24;

endpackage

// File: rtl/sed_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear and increment together yield 1.
module sed_sat_cnt #(
   parameter int unsigned W = 8
) (
   input  logic         clkout,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   always_ff @(posedge clkout or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= inc ? W'(1) : '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/sed_scan_ctrl.sv
// SED primitive initiator: one-shot/periodic CRC scans, sticky error/timeout status, saturating counters.
// Optional SED_DURATION_EN adds last_scan_cycles; all outputs are registered.
module sed_scan_ctrl
   import sed_ctrl_pkg::*;
#(
   parameter int unsigned INTERVAL_CYCLES = DEF_INTERVAL_CYCLES,
   parameter int unsigned SETUP_CYCLES    = DEF_SETUP_CYCLES,
   parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
   parameter int unsigned CNT_W           = DEF_CNT_W
) (
   input  logic             clkout,
   input  logic             reset,
   input  logic             run_en,
   input  logic             single_req,
   input  logic             inject_req,
   input  logic             err_clr,
   output logic             sed_enable,
   output logic             sed_start,
   output logic             sed_frcerr,
   input  logic             sed_done,
   input  logic             sed_inprog,
   input  logic             sed_err,
   output logic             busy,
   output logic             scan_done,
   output logic             err_flag,
   output logic             timeout_flag,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] scan_count
`ifdef SED_DURATION_EN
   ,
   output logic [DUR_W-1:0] last_scan_cycles
`endif
);

   localparam logic [31:0]      SETUP_LAST = SETUP_CYCLES - 1;
   localparam logic [31:0]      GAP_LAST   = INTERVAL_CYCLES - 1;
   localparam logic [DUR_W-1:0] TO_LAST    = DUR_W'(TIMEOUT_CYCLES - 1);

   state_t           state;
   state_t           next_state;
   logic [31:0]      cnt;
   logic [DUR_W-1:0] tcnt;
   logic             oneshot;
   logic             inject_pend;
   logic             frc_hold;

   logic             done_hit;
   logic             timeout_hit;
   logic             fire;
   logic             en_nx;
   logic             start_nx;
   logic             frc_nx;
   logic             busy_nx;
   logic             cap;
   logic             cap_err;

   always_ff @(posedge clkout or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state  = state;
      done_hit    = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (run_en || single_req) next_state = SETUP;
         end
         SETUP: begin
            if (cnt == SETUP_LAST) next_state = START;
         end
         START: begin
            if (sed_done) begin
               next_state = CAPTURE;
               done_hit   = 1'b1;
            end else if (tcnt == TO_LAST) begin
               next_state  = GAP;
               timeout_hit = 1'b1;
            end else if (sed_inprog) begin
               next_state = RUN;
            end
         end
         RUN: begin
            if (sed_done) begin
               next_state = CAPTURE;
               done_hit   = 1'b1;
            end else if (tcnt == TO_LAST) begin
               next_state  = GAP;
               timeout_hit = 1'b1;
            end
         end
         CAPTURE: begin
            next_state = GAP;
         end
         GAP: begin
            if (cnt == GAP_LAST) next_state = (run_en && !oneshot) ? SETUP : IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase

      // Outputs are registered from the next state, so they track the state with no extra lag.
      en_nx    = (next_state == SETUP) || (next_state == START) ||
                 (next_state == RUN)   || (next_state == CAPTURE);
      start_nx = (next_state == START) || (next_state == RUN);
      busy_nx  = (next_state != IDLE);
      fire     = (inject_pend || inject_req) && (next_state == RUN) && !sed_frcerr;
      frc_nx   = (next_state == RUN) && (fire || frc_hold);
      cap      = (state == CAPTURE);
      cap_err  = cap && sed_err;
   end

   always_ff @(posedge clkout or posedge reset) begin
      if (reset) begin
         cnt          <= '0;
         tcnt         <= '0;
         oneshot      <= 1'b0;
         inject_pend  <= 1'b0;
         frc_hold     <= 1'b0;
         sed_enable   <= 1'b0;
         sed_start    <= 1'b0;
         sed_frcerr   <= 1'b0;
         busy         <= 1'b0;
         scan_done    <= 1'b0;
         err_flag     <= 1'b0;
         timeout_flag <= 1'b0;
      end else begin
         cnt  <= (next_state != state) ? '0 : cnt + 32'd1;
         tcnt <= ((state == START) || (state == RUN)) ? tcnt + DUR_W'(1) : '0;

         if ((state == IDLE) && (next_state == SETUP)) oneshot <= ~run_en;

         if (fire)            inject_pend <= 1'b0;
         else if (inject_req) inject_pend <= 1'b1;
         frc_hold <= fire;

         sed_enable <= en_nx;
         sed_start  <= start_nx;
         sed_frcerr <= frc_nx;
         busy       <= busy_nx;
         scan_done  <= done_hit || timeout_hit;

         // A capture that sees an error takes priority over a same-cycle clear.
         if (cap_err)      err_flag <= 1'b1;
         else if (err_clr) err_flag <= 1'b0;

         if (timeout_hit)  timeout_flag <= 1'b1;
         else if (err_clr) timeout_flag <= 1'b0;
      end
   end

`ifdef SED_DURATION_EN
   always_ff @(posedge clkout or posedge reset) begin
      if (reset) begin
         last_scan_cycles <= '0;
      end else if (done_hit) begin
         last_scan_cycles <= tcnt;
      end else if (timeout_hit) begin
         last_scan_cycles <= '1;
      end
   end
`endif

   sed_sat_cnt #(.W(CNT_W)) u_err_cnt (
      .clkout (clkout),
      .reset  (reset),
      .inc    (cap_err),
      .clr    (err_clr),
      .count  (err_count)
   );

   sed_sat_cnt #(.W(CNT_W)) u_scan_cnt (
      .clkout (clkout),
      .reset  (reset),
      .inc    (cap),
      .clr    (1'b0),
      .count  (scan_count)
   );

endmodule

// File: tb/tb_sed_scan_ctrl.sv
// Bench for sed_scan_ctrl: behavioural SED primitive stub, randomized scans, status scoreboard.
module tb_sed_scan_ctrl;

   localparam int INTERVAL = 8;
   localparam int SETUPC   = 4;
   localparam int TIMEOUT  = 64;
   localparam int CW       = 8;

   logic clkout = 1'b0;
   logic reset = 1'b1;
   logic run_en = 1'b0, single_req = 1'b0, inject_req = 1'b0, err_clr = 1'b0;
   logic sed_done = 1'b0, sed_inprog = 1'b0, sed_err = 1'b0;
   logic sed_enable, sed_start, sed_frcerr, busy, scan_done, err_flag, timeout_flag;
   logic [CW-1:0] err_count, scan_count;
`ifdef SED_DURATION_EN
   logic [23:0] last_scan_cycles;
`endif

   always #5 clkout = ~clkout;

   sed_scan_ctrl #(
      .INTERVAL_CYCLES (INTERVAL),
      .SETUP_CYCLES    (SETUPC),
      .TIMEOUT_CYCLES  (TIMEOUT),
      .CNT_W           (CW)
   ) dut (
      .clkout       (clkout),
      .reset        (reset),
      .run_en       (run_en),
      .single_req   (single_req),
      .inject_req   (inject_req),
      .err_clr      (err_clr),
      .sed_enable   (sed_enable),
      .sed_start    (sed_start),
      .sed_frcerr   (sed_frcerr),
      .sed_done     (sed_done),
      .sed_inprog   (sed_inprog),
      .sed_err      (sed_err),
      .busy         (busy),
      .scan_done    (scan_done),
      .err_flag     (err_flag),
      .timeout_flag (timeout_flag),
      .err_count    (err_count),
      .scan_count   (scan_count)
`ifdef SED_DURATION_EN
      ,
      .last_scan_cycles (last_scan_cycles)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Primitive stub: inprog 2 cycles after the start edge, done (+err if forced) 20 cycles later.
   bit hang = 0;
   bit running = 0, saw_frc = 0, start_q = 0;
   int sc = 0;
   always @(negedge clkout) begin
      if (reset || !sed_enable) begin
         running = 0; sed_inprog = 0; sed_done = 0; sed_err = 0; saw_frc = 0;
      end else begin
         if (sed_start && !start_q) begin
            running = 1; sc = 0; sed_done = 0; sed_err = 0; sed_inprog = 0; saw_frc = 0;
         end else if (running) begin
            sc++;
         end
         if (running && sed_frcerr) saw_frc = 1;
         if (running && sc == 2) sed_inprog = 1;
         if (running && !hang && sc == 22) begin
            sed_done = 1; sed_inprog = 0; sed_err = saw_frc; running = 0;
         end
      end
      start_q = sed_start;
   end

   // Waveform monitor: setup length, idle gap length, force-error pulse shape, done pulses.
   bit en_q = 0, busy_q = 0, started = 0;
   int setup_len = 0, gap_len = 0, frc_len = 0, frc_first = -1;
   int start_off = 0, done_cnt = 0, last_done_off = 0;
   always @(negedge clkout) begin
      if (reset) begin
         en_q = 0; busy_q = 0; started = 0; gap_len = 0; setup_len = 0;
      end else begin
         if (sed_enable && !en_q) begin
            if (gap_len != 0) chk("gap_len", gap_len, INTERVAL);
            gap_len = 0; setup_len = 0; started = 0;
         end
         if (sed_start && !started) begin
            chk("setup_len", setup_len, SETUPC);
            started = 1; start_off = 0; frc_len = 0; frc_first = -1;
         end else begin
            start_off++;
         end
         if (sed_enable && !started) setup_len++;
         if (sed_frcerr) begin
            frc_len++;
            if (frc_first < 0) frc_first = start_off;
         end
         if (busy && !sed_enable) gap_len++;
         if (!busy && busy_q) begin
            if (gap_len != 0) chk("idle_gap", gap_len, INTERVAL);
            gap_len = 0;
         end
         if (scan_done) begin
            done_cnt++; last_done_off = start_off;
         end
         en_q = sed_enable; busy_q = busy;
      end
   end

   // Scoreboard of the status register block.
   int m_scan = 0, m_err = 0;
   bit m_eflag = 0, m_tflag = 0;

   function automatic int sat(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   task automatic tick();
      @(negedge clkout);
      #1;
   endtask

   task automatic wait_done(input int bound, output bit ok);
      ok = 0;
      for (int i = 0; i < bound; i++) begin
         tick();
         if (scan_done) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("done_timeout", 0, 1);
   endtask

   task automatic wait_idle(input int bound);
      for (int i = 0; i < bound && busy; i++) tick();
      chk("idle_reached", busy, 0);
   endtask

   task automatic wait_inprog(input int bound);
      for (int i = 0; i < bound && !sed_inprog; i++) tick();
      chk("inprog_seen", sed_inprog, 1);
   endtask

   task automatic check_status(input string tag);
      chk({tag, "_scan_count"}, scan_count, m_scan);
      chk({tag, "_err_count"}, err_count, m_err);
      chk({tag, "_err_flag"}, err_flag, m_eflag);
      chk({tag, "_timeout_flag"}, timeout_flag, m_tflag);
   endtask

   task automatic clear_errs();
      err_clr = 1; tick(); err_clr = 0;
      m_err = 0; m_eflag = 0; m_tflag = 0;
   endtask

   // mode: 0 clean, 1 inject before start, 2 inject mid-RUN, 3 injection already pending
   task automatic do_scan(input int mode);
      bit ok;
      int d0;
      d0 = done_cnt;
      if (mode == 1) begin
         inject_req = 1; tick(); inject_req = 0;
      end
      single_req = 1; tick(); single_req = 0;
      if (mode == 2) begin
         wait_inprog(40);
         repeat ($urandom_range(0, 8)) tick();
         inject_req = 1; tick(); inject_req = 0;
      end
      wait_done(200, ok);
      if (ok) begin
         m_scan = sat(m_scan + 1);
         if (mode != 0) begin
            m_err = sat(m_err + 1);
            m_eflag = 1;
         end
      end
      chk("frc_len", frc_len, (mode != 0) ? 2 : 0);
      wait_idle(40);
      check_status("scan");
      chk("done_pulses", done_cnt - d0, 1);
   endtask

   initial begin
      bit ok;
      int d0;

      // Reset state
      repeat (3) tick();
      chk("rst_enable", sed_enable, 0);
      chk("rst_start", sed_start, 0);
      chk("rst_frcerr", sed_frcerr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_scan_done", scan_done, 0);
      check_status("rst");
      reset = 0;
      repeat (2) tick();
      chk("idle_busy", busy, 0);

      // Single scan; a second single_req while busy is ignored
      d0 = done_cnt;
      single_req = 1; tick(); single_req = 0;
      chk("en_next_cycle", sed_enable, 1);
      chk("busy_set", busy, 1);
      wait_inprog(40);
      single_req = 1; tick(); single_req = 0;
      wait_done(200, ok);
      if (ok) m_scan = sat(m_scan + 1);
`ifdef SED_DURATION_EN
      chk("dur_normal", last_scan_cycles, 22);
`endif
      wait_idle(40);
      repeat (4) tick();
      chk("busy_stays_low", busy, 0);
      chk("single_done_pulses", done_cnt - d0, 1);
      check_status("single");

      // Injection requested during GAP fires in the first RUN cycles of the next scan
      single_req = 1; tick(); single_req = 0;
      wait_done(200, ok);
      if (ok) m_scan = sat(m_scan + 1);
      tick();
      inject_req = 1; tick(); inject_req = 0;
      wait_idle(40);
      do_scan(3);
      chk("frc_first_run_cycle", frc_first, 3);

      // err_clr clears error state but not scan_count
      clear_errs();
      check_status("clr");

      // Periodic scanning; run_en dropped mid scan 3
      d0 = done_cnt;
      run_en = 1;
      wait_done(200, ok);
      wait_done(200, ok);
      tick();
      wait_inprog(60);
      repeat (5) tick();
      run_en = 0;
      wait_done(200, ok);
      m_scan = sat(m_scan + 3);
      wait_idle(40);
      repeat (4) tick();
      chk("periodic_done_pulses", done_cnt - d0, 3);
      chk("periodic_idle", busy, 0);
      check_status("periodic");

      // Timeout: primitive never reports done
      hang = 1;
      d0 = done_cnt;
      single_req = 1; tick(); single_req = 0;
      wait_done(200, ok);
      m_tflag = 1;
      chk("to_latency", last_done_off, TIMEOUT);
      chk("to_enable_low", sed_enable, 0);
      chk("to_flag_now", timeout_flag, 1);
`ifdef SED_DURATION_EN
      chk("dur_timeout", last_scan_cycles, 24'hFFFFFF);
`endif
      wait_idle(40);
      hang = 0;
      chk("to_done_pulses", done_cnt - d0, 1);
      check_status("timeout");

      // Randomized scans with random injection style and random clears
      repeat (12) begin
         do_scan(int'($urandom_range(0, 2)));
         if ($urandom_range(0, 3) == 0) begin
            clear_errs();
            check_status("rand_clr");
         end
         repeat ($urandom_range(0, 4)) tick();
      end

      // Saturation of both counters
      repeat (256) do_scan(1);
      chk("err_sat", err_count, 255);
      chk("scan_sat", scan_count, 255);

      // err_clr in the same cycle as an error capture: capture wins
      inject_req = 1; tick(); inject_req = 0;
      single_req = 1; tick(); single_req = 0;
      wait_done(200, ok);
      err_clr = 1; tick(); err_clr = 0;
      m_scan = sat(m_scan + 1); m_err = 1; m_eflag = 1; m_tflag = 0;
      wait_idle(40);
      check_status("clr_vs_capture");

      // Asynchronous reset while in RUN
      single_req = 1; tick(); single_req = 0;
      wait_inprog(40);
      repeat (3) tick();
      #2 reset = 1;
      #1;
      chk("arst_enable", sed_enable, 0);
      chk("arst_start", sed_start, 0);
      chk("arst_frcerr", sed_frcerr, 0);
      chk("arst_busy", busy, 0);
      chk("arst_scan_done", scan_done, 0);
      m_scan = 0; m_err = 0; m_eflag = 0; m_tflag = 0;
      check_status("arst");
      repeat (2) tick();
      reset = 0;
      repeat (2) tick();
      do_scan(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog got=expired exp=finished");
      $fatal(1);
   end

endmodule

// File: doc/sed_scan_ctrl.md
Name: sed_scan_ctrl

Overview:
- Fabric-side initiator for the on-chip soft-error-detection (SED) primitive.
- Sequences the primitive's enable/start/force-error inputs and watches its done/in-progress/error outputs.
- Runs one-shot or periodic configuration-CRC scans and keeps sticky error/timeout status plus saturating counters for the system status register block.

Parameters:
- INTERVAL_CYCLES, 1024: idle gap between periodic scans, with sed_enable low; minimum 2.
- SETUP_CYCLES, 4: cycles sed_enable is high before sed_start rises; minimum 1.
- TIMEOUT_CYCLES, 2097152: maximum cycles from sed_start rise to sed_done; must exceed the largest device scan length (1887748).
- CNT_W, 8: width of err_count and scan_count.

Ports:
- clkout  in  1  free-running SED oscillator clock, ungated; never the enable-gated SED clock output.
- reset  in  1  asynchronous, active-high.
- run_en  in  1  level: continuous periodic scanning.
- single_req  in  1  pulse: one scan; ignored while busy.
- inject_req  in  1  pulse: force an error on the next or current scan.
- err_clr  in  1  pulse: clear err_flag, timeout_flag, err_count.
- sed_enable  out  1  to primitive.
- sed_start  out  1  to primitive; rising edge starts a scan.
- sed_frcerr  out  1  to primitive.
- sed_done  in  1  from primitive; stays high until enable drops or a new start.
- sed_inprog  in  1  from primitive.
- sed_err  in  1  from primitive; valid when sed_done is high.
- busy  out  1  high in any state except IDLE.
- scan_done  out  1  one-cycle pulse per completed or timed-out scan.
- err_flag  out  1  sticky: a scan reported an error.
- timeout_flag  out  1  sticky: a scan did not finish in time.
- err_count  out  CNT_W  saturating count of error scans.
- scan_count  out  CNT_W  saturating count of completed scans; never cleared by err_clr.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; inject_pend cleared.
- All inputs are synchronous to clkout. Outputs are registered, with no combinational path from input to output.
- FSM states and transitions:
  - IDLE: leave on run_en=1 or single_req=1, go to SETUP. Latch oneshot = ~run_en.
  - SETUP: sed_enable=1. After SETUP_CYCLES cycles go to START.
  - START: sed_enable=1, sed_start=1; the timeout counter runs from this state's first cycle.
    - sed_inprog=1 → RUN.
    - sed_done=1 (short scan) → CAPTURE.
  - RUN: sed_start stays 1 (level is harmless; only the edge matters). Wait for sed_done=1 → CAPTURE.
  - CAPTURE: one cycle.
    - sed_start=0.
    - Sample sed_err: if 1, set err_flag and increment err_count.
    - Increment scan_count.
    - Pulse scan_done.
    - Then go to GAP.
  - GAP: sed_enable=0, sed_start=0, sed_frcerr=0, for INTERVAL_CYCLES cycles.
    - Then, if run_en=1 and not oneshot → SETUP; otherwise → IDLE.
- Timeout: in START or RUN, when the counter reaches TIMEOUT_CYCLES-1 without sed_done:
  - set timeout_flag, pulse scan_done, go to GAP;
  - scan_count does not increment.
- Injection:
  - inject_req sets inject_pend in any state.
  - On the first RUN cycle with inject_pend=1, drive sed_frcerr=1 for exactly 2 cycles, then clear inject_pend.
  - A request arriving mid-RUN fires immediately.
  - A request arriving in GAP or IDLE waits for the next RUN.
- run_en dropped mid-scan: the current scan completes normally, then GAP → IDLE.
- single_req while busy: ignored.
- err_clr in the same cycle as a CAPTURE that sees an error: the capture wins, leaving err_flag=1 and err_count=1.
- Counters saturate at all-ones; there is no wrap-around.
- Reset mid-scan: outputs return to 0 immediately, and the primitive is reinitialised through sed_enable=0.

Optional Feature:
- Macro SED_DURATION_EN.
- Defined:
  - adds output last_scan_cycles, 24 bits, reset 0;
  - loaded in CAPTURE with the cycle count from START entry to sed_done;
  - loaded with all-ones on timeout.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package sed_ctrl_pkg holds:
  - state enum (IDLE, SETUP, START, RUN, CAPTURE, GAP);
  - default parameter constants;
  - the maximum scan length constant 1887748.
- One sub-module, sed_sat_cnt: parameterised-width saturating counter with inc and clr inputs; instantiated for err_count and scan_count.

Test Plan:
- Use INTERVAL_CYCLES=8, SETUP_CYCLES=4, TIMEOUT_CYCLES=64 with a behavioural primitive stub (inprog 2 cycles after start, done 20 cycles later).
- single_req pulse → sed_enable rises next cycle; sed_start rises 4 cycles later; scan_done pulses once; scan_count=1; err_flag=0; busy returns to 0 after 8 GAP cycles.
- run_en held for 3 scans → scan_count=3, each separated by exactly 8 cycles of sed_enable=0; run_en dropped mid-scan 3 → that scan completes, then IDLE.
- inject_req during GAP → sed_frcerr high exactly 2 cycles in the first RUN cycles; the stub asserts sed_err → err_flag=1, err_count=1; err_clr → both 0, scan_count unchanged.
- Stub never asserts done → timeout_flag=1 after 64 cycles, scan_done pulses, scan_count unchanged, sed_enable low in GAP.
- err_count preloaded to 255 by repeated injected scans → stays 255; err_clr coinciding with an error capture → err_flag=1, err_count=1.
- reset asserted in RUN → all outputs 0 asynchronously; with SED_DURATION_EN, a normal scan gives last_scan_cycles=22.
